trig_stretch_sched: RTL and testbench
=====================================

Name: trig_stretch_sched

Overview:
Multi-channel trigger pulse scheduler that sequences the pulse-stretch function for NCH independent discriminator inputs. Per channel it provides a programmable delay, a programmable output width and a hold-off (dead time). It also applies a retrigger policy and counts triggers lost while a channel is busy. It sits between the fast-trigger inputs and the coincidence/output logic. Configuration arrives from the slow-control register bus through shadow registers.

Parameters:
NCH, 4, number of trigger channels
W_W, 10, width-counter bits (0 encodes 2^W_W cycles)
D_W, 8, delay-counter bits
H_W, 8, hold-off-counter bits

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
din  in  NCH  raw trigger levels, already synchronous to clk
cfg_we  in  1  config write strobe, one cycle
cfg_ch  in  2  target channel
cfg_sel  in  2  0=width, 1=delay, 2=holdoff, 3=mode (bit0 retrigger, bit1 enable)
cfg_wdata  in  16  write data, LSB-aligned, truncated to field width
cnt_clr  in  1  clears lost counter
dout  out  NCH  stretched, delayed trigger per channel
dout_or  out  1  registered OR of dout (one cycle after dout)
busy  out  NCH  channel not in IDLE
lost_cnt  out  16  saturating count of rejected edges

Behaviour:
- Reset: dout, dout_or and busy = 0; lost_cnt = 0; all FSMs IDLE; edge registers = 0. Shadow config resets to width=1, delay=0, holdoff=0, mode=2'b10 (enabled, no retrigger). Reset mid-pulse drops dout at the resetting clock edge.
- Edge detect: per channel, two-stage register s1<=din, s2<=s1; edge = s1 & ~s2.
- Timing: din first sampled high at edge k. With delay D the first dout high is at edge k+1+D. dout stays high exactly W cycles, or 2^W_W cycles when W=0.
- FSM per channel: IDLE, DELAY, ACTIVE, HOLDOFF.
  - IDLE + edge + enabled: if D=0, go to ACTIVE with dout=1 and width counter loaded; else go to DELAY with counter = D-1. Edge while disabled is ignored and not counted.
  - DELAY: count down; at 0 go to ACTIVE with dout=1.
  - ACTIVE: count W cycles; on the last cycle dout=0, then go to HOLDOFF if H>0, else IDLE.
  - HOLDOFF: H cycles, then IDLE. An edge in the final HOLDOFF cycle is lost.
- Edges arriving in DELAY or HOLDOFF are lost. An edge in ACTIVE restarts the width count (dout stays high, full W from that cycle) if retrigger=1; otherwise it is lost.
- Config latching: width, delay, holdoff and mode are sampled from shadow when leaving IDLE and held until the next return to IDLE.
  - A cfg write in the same cycle as a triggering edge: the trigger uses the old shadow value.
  - A write to a busy channel affects only its next trigger. Exception: mode.enable=0 takes effect immediately and forces the channel to IDLE, dropping dout next edge.
- lost_cnt: adds the number of channels losing an edge that cycle (0..NCH) and saturates at 16'hFFFF. cnt_clr has priority over increments in the same cycle.
- busy = (state != IDLE), registered with the state.

Test Plan:
- ch0 width=5, delay=0: din 0→1 sampled at edge 10 → dout[0] high edges 11–15, dout_or high 12–16, lost_cnt=0.
- ch1 width=3, delay=4, holdoff=6: pulse at edge 20 → dout[1] high 25–27. A second edge 2 cycles after dout falls → rejected, lost_cnt=1, no output.
- ch2 retrigger=1, width=8: edges at 0 and 5 → dout[2] high 1–13 continuous. Same with retrigger=0 → high 1–8, lost_cnt=1.
- width=0 → dout high for exactly 1024 cycles. Write width=2 during ACTIVE → current pulse still 1024 cycles, next pulse 2 cycles.
- All 4 channels edge simultaneously while busy, lost_cnt preset near 16'hFFFE → saturates at 16'hFFFF. cnt_clr coincident with losses → 0.
- Assert rst while ch3 ACTIVE → dout[3]=0 and busy=0 at that edge, shadow back to defaults. Disable ch3 mid-DELAY → returns to IDLE, no pulse.

Source files
------------

// File: rtl/trig_stretch_sched.sv
// Multi-channel trigger pulse scheduler: per-channel delay, stretched output width,
// hold-off dead time, optional retrigger, and a saturating count of rejected edges.
`timescale 1ns/1ps
module trig_stretch_sched #(
    parameter int NCH = 4,
    parameter int W_W = 10,
    parameter int D_W = 8,
    parameter int H_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] din,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_ch,
    input  logic [1:0]     cfg_sel,
    input  logic [15:0]    cfg_wdata,
    input  logic           cnt_clr,
    output logic [NCH-1:0] dout,
    output logic           dout_or,
    output logic [NCH-1:0] busy,
    output logic [15:0]    lost_cnt
);

    localparam int CW_A = (W_W > D_W) ? W_W : D_W;
    localparam int CW   = (CW_A > H_W) ? CW_A : H_W;
    localparam int LC_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] edge_vec;
    logic [NCH-1:0] lost_vec;
    logic [15:0]    lost_cnt_q;
    logic           dout_or_q;
    logic [LC_W-1:0] n_lost;
    logic [16:0]    lost_sum;
    logic           unused_wdata_hi;

    assign unused_wdata_hi = ^cfg_wdata[15:W_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    assign edge_vec = s1_q & ~s2_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi = gi + 1) begin : g_ch
            state_t          state_q, state_d;
            logic [CW-1:0]   cnt_q, cnt_d;
            logic            dout_q, dout_d;
            logic            busy_q;
            logic [W_W-1:0]  sh_wid_q;
            logic [D_W-1:0]  sh_dly_q;
            logic [H_W-1:0]  sh_hold_q;
            logic [1:0]      sh_mode_q;
            logic [W_W-1:0]  wid_q, wid_d;
            logic [H_W-1:0]  hold_q, hold_d;
            logic            retrig_q, retrig_d;
            logic [W_W-1:0]  sh_wid_m1;
            logic [W_W-1:0]  wid_m1;
            logic [D_W-1:0]  sh_dly_m1;
            logic [H_W-1:0]  hold_m1;
            logic            wr_sel;
            logic            dis_now;
            logic            lost;

            assign wr_sel    = cfg_we && (cfg_ch == 2'(gi));
            assign dis_now   = wr_sel && (cfg_sel == 2'd3) && !cfg_wdata[1];
            // Width 0 wraps to all-ones here, giving the full 2^W_W-cycle pulse.
            assign sh_wid_m1 = sh_wid_q - W_W'(1);
            assign wid_m1    = wid_q - W_W'(1);
            assign sh_dly_m1 = sh_dly_q - D_W'(1);
            assign hold_m1   = hold_q - H_W'(1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_wid_q  <= W_W'(1);
                    sh_dly_q  <= '0;
                    sh_hold_q <= '0;
                    sh_mode_q <= 2'b10;
                end else if (wr_sel) begin
                    case (cfg_sel)
                        2'd0:    sh_wid_q  <= cfg_wdata[W_W-1:0];
                        2'd1:    sh_dly_q  <= cfg_wdata[D_W-1:0];
                        2'd2:    sh_hold_q <= cfg_wdata[H_W-1:0];
                        default: sh_mode_q <= cfg_wdata[1:0];
                    endcase
                end
            end

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                dout_d   = dout_q;
                wid_d    = wid_q;
                hold_d   = hold_q;
                retrig_d = retrig_q;
                lost     = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (edge_vec[gi] && sh_mode_q[1]) begin
                            wid_d    = sh_wid_q;
                            hold_d   = sh_hold_q;
                            retrig_d = sh_mode_q[0];
                            if (sh_dly_q == '0) begin
                                state_d = S_ACTIVE;
                                dout_d  = 1'b1;
                                cnt_d   = CW'(sh_wid_m1);
                            end else begin
                                state_d = S_DELAY;
                                cnt_d   = CW'(sh_dly_m1);
                            end
                        end
                    end
                    S_DELAY: begin
                        lost = edge_vec[gi];
                        if (cnt_q == '0) begin
                            state_d = S_ACTIVE;
                            dout_d  = 1'b1;
                            cnt_d   = CW'(wid_m1);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (edge_vec[gi] && retrig_q) begin
                            cnt_d = CW'(wid_m1);
                        end else begin
                            lost = edge_vec[gi];
                            if (cnt_q == '0) begin
                                dout_d = 1'b0;
                                if (hold_q != '0) begin
                                    state_d = S_HOLDOFF;
                                    cnt_d   = CW'(hold_m1);
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
                    end
                    default: begin
                        lost = edge_vec[gi];
                        if (cnt_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                endcase
                // Disabling a channel aborts whatever it is doing, regardless of state.
                if (dis_now) begin
                    state_d = S_IDLE;
                    dout_d  = 1'b0;
                    lost    = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    dout_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    wid_q    <= W_W'(1);
                    hold_q   <= '0;
                    retrig_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    dout_q   <= dout_d;
                    busy_q   <= (state_d != S_IDLE);
                    wid_q    <= wid_d;
                    hold_q   <= hold_d;
                    retrig_q <= retrig_d;
                end
            end

            assign lost_vec[gi] = lost;
            assign dout[gi]     = dout_q;
            assign busy[gi]     = busy_q;
        end
    endgenerate

    always_comb begin
        n_lost = '0;
        for (int i = 0; i < NCH; i++) begin
            n_lost = n_lost + LC_W'(lost_vec[i]);
        end
    end

    assign lost_sum = {1'b0, lost_cnt_q} + 17'(n_lost);

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt_q <= '0;
            dout_or_q  <= 1'b0;
        end else begin
            dout_or_q <= |dout;
            if (cnt_clr) begin
                lost_cnt_q <= '0;
            end else if (lost_sum[16]) begin
                lost_cnt_q <= 16'hFFFF;
            end else begin
                lost_cnt_q <= lost_sum[15:0];
            end
        end
    end

    assign lost_cnt = lost_cnt_q;
    assign dout_or  = dout_or_q;

endmodule

// File: tb/tb_trig_stretch_sched.sv
// Scoreboard bench: every stimulus pushes the pulse(s) it should cause; a monitor
// pops and compares start edge and length whenever a dout pulse ends.
`timescale 1ns/1ps
module tb_trig_stretch_sched;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] din = '0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [1:0]     cfg_sel = '0;
    logic [15:0]    cfg_wdata = '0;
    logic           cnt_clr = 1'b0;
    logic [NCH-1:0] dout;
    logic           dout_or;
    logic [NCH-1:0] busy;
    logic [15:0]    lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_lost = 0;

    typedef struct {
        int ch;
        int start;
        int len;
    } exp_t;
    exp_t sb[$];

    trig_stretch_sched dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cnt_clr   (cnt_clr),
        .dout      (dout),
        .dout_or   (dout_or),
        .busy      (busy),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input int start, input int len);
        exp_t e;
        e.ch = ch;
        e.start = start;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic cfg_wr(input int ch, input int sel, input int data);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_sel   = 2'(sel);
        cfg_wdata = 16'(data);
        step();
        cfg_we    = 1'b0;
    endtask

    // Raises din for one sampled cycle; k is the edge that first samples it high.
    task automatic fire(input logic [NCH-1:0] mask, output int k);
        k = cyc + 1;
        din = mask;
        step();
        din = '0;
    endtask

    // One 1280-cycle period with all channels at width 1024, hold-off 255 and din
    // toggling every cycle: one accepted edge and 639 rejected edges per channel.
    task automatic run_period(input int clr_at);
        int k;
        k = cyc + 1;
        for (int c = 0; c < NCH; c++) push_exp(c, k + 1, 1024);
        for (int i = 0; i < 1280; i++) begin
            if (clr_at >= 0 && i == clr_at + 1) check_eq("clr_vs_loss", lost_cnt, 0);
            din     = (i % 2 == 0) ? '1 : '0;
            cnt_clr = (i == clr_at);
            step();
        end
        din     = '0;
        cnt_clr = 1'b0;
        if (clr_at >= 0) exp_lost = 4 * ((1278 - (clr_at + 1)) / 2 + 1);
        else exp_lost = (exp_lost + 4 * 639 > 65535) ? 65535 : exp_lost + 4 * 639;
        check_eq("lost_period", lost_cnt, exp_lost);
    endtask

    logic [NCH-1:0] prev_dout = '0;
    int rise_at[NCH];

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (dout[c] === 1'b1 && prev_dout[c] == 1'b0) rise_at[c] = cyc;
            if (dout[c] === 1'b0 && prev_dout[c] == 1'b1) begin
                int idx;
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].ch == c) idx = j;
                end
                $display("pulse ch=%0d start=%0d len=%0d", c, rise_at[c], cyc - rise_at[c]);
                if (idx < 0) begin
                    check_eq("unexpected_pulse", 1, 0);
                end else begin
                    check_eq("pulse_start", rise_at[c], sb[idx].start);
                    check_eq("pulse_len", cyc - rise_at[c], sb[idx].len);
                    sb.delete(idx);
                end
            end
            prev_dout[c] = (dout[c] === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;

        // Reset state
        step(3);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_dout_or", dout_or, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_lost", lost_cnt, 0);
        rst = 1'b0;
        step(2);

        // ch0: width 5, no delay
        cfg_wr(0, 0, 5);
        fire(4'b0001, k);
        push_exp(0, k + 1, 5);
        wait_cyc(k + 1);
        check_eq("ch0_first_high", dout[0], 1);
        check_eq("or_lags_dout", dout_or, 0);
        wait_cyc(k + 2);
        check_eq("or_high", dout_or, 1);
        check_eq("ch0_busy", busy[0], 1);
        wait_cyc(k + 6);
        check_eq("ch0_fallen", dout[0], 0);
        check_eq("or_last_high", dout_or, 1);
        wait_cyc(k + 7);
        check_eq("or_low", dout_or, 0);
        check_eq("ch0_idle", busy[0], 0);
        check_eq("lost_zero", lost_cnt, 0);

        // Width write coincident with the triggering edge uses the old width
        din = 4'b0001;
        step();
        k = cyc;
        din = '0;
        push_exp(0, k + 1, 5);
        cfg_wr(0, 0, 7);
        wait_cyc(k + 10);
        fire(4'b0001, k);
        push_exp(0, k + 1, 7);
        wait_cyc(k + 12);

        // ch1: delay 4, width 3, hold-off 6; edges in hold-off are lost
        cfg_wr(1, 0, 3);
        cfg_wr(1, 1, 4);
        cfg_wr(1, 2, 6);
        fire(4'b0010, k);
        push_exp(1, k + 5, 3);
        wait_cyc(k + 9);
        fire(4'b0010, k2);
        wait_cyc(k + 12);
        fire(4'b0010, k2);
        exp_lost += 2;
        check_eq("ch1_final_holdoff_busy", busy[1], 1);
        wait_cyc(k + 14);
        check_eq("ch1_back_idle", busy[1], 0);
        wait_cyc(k + 16);
        check_eq("ch1_lost", lost_cnt, exp_lost);
        fire(4'b0010, k);
        push_exp(1, k + 5, 3);
        wait_cyc(k + 20);

        // ch2: retrigger extends the pulse; without retrigger the edge is lost
        cfg_wr(2, 0, 8);
        cfg_wr(2, 3, 3);
        fire(4'b0100, k);
        push_exp(2, k + 1, 13);
        wait_cyc(k + 4);
        fire(4'b0100, k2);
        wait_cyc(k + 20);
        check_eq("retrig_no_loss", lost_cnt, exp_lost);
        cfg_wr(2, 3, 2);
        fire(4'b0100, k);
        push_exp(2, k + 1, 8);
        wait_cyc(k + 4);
        fire(4'b0100, k2);
        exp_lost += 1;
        wait_cyc(k + 20);
        check_eq("noretrig_lost", lost_cnt, exp_lost);

        // ch0: width 0 means 1024 cycles; a width write mid-pulse affects only the next one
        cfg_wr(0, 0, 0);
        fire(4'b0001, k);
        push_exp(0, k + 1, 1024);
        wait_cyc(k + 100);
        cfg_wr(0, 0, 2);
        wait_cyc(k + 1030);
        check_eq("w0_done", busy[0], 0);
        fire(4'b0001, k);
        push_exp(0, k + 1, 2);
        wait_cyc(k + 10);

        // Saturation of lost_cnt, then cnt_clr coincident with losses
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_lost = 0;
        check_eq("clr_idle", lost_cnt, 0);
        for (int c = 0; c < NCH; c++) begin
            cfg_wr(c, 0, 0);
            cfg_wr(c, 1, 0);
            cfg_wr(c, 2, 255);
            cfg_wr(c, 3, 2);
        end
        for (int p = 0; p < 26; p++) run_period(-1);
        check_eq("lost_saturated", lost_cnt, 16'hFFFF);
        run_period(5);
        step(2);

        // ch3: disable during DELAY aborts with no pulse; disabled edges are not counted
        cfg_wr(3, 0, 4);
        cfg_wr(3, 1, 10);
        cfg_wr(3, 2, 0);
        fire(4'b1000, k);
        wait_cyc(k + 3);
        check_eq("ch3_in_delay", busy[3], 1);
        cfg_wr(3, 3, 0);
        check_eq("ch3_disabled_idle", busy[3], 0);
        wait_cyc(k + 20);
        fire(4'b1000, k);
        wait_cyc(k + 6);
        check_eq("ch3_disabled_ignore", busy[3], 0);
        check_eq("ch3_disabled_nolost", lost_cnt, exp_lost);

        // ch3: reset mid-pulse drops dout at the resetting edge and restores defaults
        cfg_wr(3, 3, 2);
        cfg_wr(3, 1, 0);
        cfg_wr(3, 0, 20);
        fire(4'b1000, k);
        wait_cyc(k + 5);
        check_eq("ch3_active", dout[3], 1);
        push_exp(3, k + 1, 5);
        rst = 1'b1;
        step();
        check_eq("rst_mid_dout", dout[3], 0);
        check_eq("rst_mid_busy", busy[3], 0);
        check_eq("rst_mid_lost", lost_cnt, 0);
        rst = 1'b0;
        step();
        fire(4'b1000, k);
        push_exp(3, k + 1, 1);
        wait_cyc(k + 3);
        check_eq("default_width_done", busy[3], 0);
        wait_cyc(k + 10);

        check_eq("pending_pulses", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
